// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - clock-configuration bit positions, source encodings and sequencer states
package clk_pkg;

    localparam int CFG_RESET  = 7;
    localparam int CFG_PLLENA = 6;
    localparam int CFG_OSCENA = 5;
    localparam int CFG_OSCM1  = 4;
    localparam int CFG_OSCM0  = 3;

    localparam logic [2:0] RCFAST = 3'd0;
    localparam logic [2:0] RCSLOW = 3'd1;
    localparam logic [2:0] XINPUT = 3'd2;
    localparam logic [2:0] PLL1X  = 3'd3;
    localparam logic [2:0] PLL2X  = 3'd4;
    localparam logic [2:0] PLL4X  = 3'd5;
    localparam logic [2:0] PLL8X  = 3'd6;
    localparam logic [2:0] PLL16X = 3'd7;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE      = 2'd1,
        RESET_PULSE = 2'd2
    } clkseq_state_t;

endpackage

// File: rtl/clkset_sequencer.sv
// rtl/clkset_sequencer.sv - CLKSET register owner: settle hold-off on new enables and timed soft reset
module clkset_sequencer
    import clk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1600000,
    parameter int RESET_CYCLES  = 16,
    parameter int CNT_W = $clog2(((SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES) + 1)
) (
    input  logic       clock_160,
    input  logic       res,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [6:0] cfg,
    output logic       settling,
    output logic       soft_res
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [6:0]       CFG_RST     = {4'b0000, RCFAST};

    clkseq_state_t    r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [6:0]       r_cfg, w_cfg_n;
    logic [6:0]       r_pend, w_pend_n;
    logic             r_wr_ready, r_settling, r_soft_res;
    logic             w_accept, w_rising;

    assign w_accept = wr_valid && r_wr_ready && (r_state == IDLE);
    assign w_rising = (wr_data[CFG_PLLENA] & ~r_cfg[CFG_PLLENA]) |
                      (wr_data[CFG_OSCENA] & ~r_cfg[CFG_OSCENA]);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cfg_n   = r_cfg;
        w_pend_n  = r_pend;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (wr_data[CFG_RESET]) begin
                        w_state_n = RESET_PULSE;
                        w_cfg_n   = CFG_RST;
                        w_cnt_n   = RESET_LOAD;
                    end else if (w_rising && (SETTLE_CYCLES > 0)) begin
                        // Enables and oscillator mode go out now; the source switch waits.
                        w_state_n = SETTLE;
                        w_cfg_n   = {wr_data[CFG_PLLENA:CFG_OSCM0], r_cfg[2:0]};
                        w_pend_n  = wr_data[6:0];
                        w_cnt_n   = SETTLE_LOAD;
                    end else begin
                        w_cfg_n = wr_data[6:0];
                    end
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_n = IDLE;
                    w_cfg_n   = r_pend;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            RESET_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cfg_n   = CFG_RST;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cfg      <= CFG_RST;
            r_pend     <= CFG_RST;
            r_wr_ready <= 1'b0;
            r_settling <= 1'b0;
            r_soft_res <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_cfg      <= w_cfg_n;
            r_pend     <= w_pend_n;
            r_wr_ready <= (w_state_n == IDLE);
            r_settling <= (w_state_n == SETTLE);
            r_soft_res <= (w_state_n == RESET_PULSE);
        end
    end

    assign wr_ready = r_wr_ready;
    assign cfg      = r_cfg;
    assign settling = r_settling;
    assign soft_res = r_soft_res;

endmodule

// File: tb/tb_clkset_sequencer.sv
// tb/tb_clkset_sequencer.sv - directed bench for clkset_sequencer
module tb_clkset_sequencer;

    logic       clock_160 = 1'b0;
    logic       res       = 1'b1;
    logic       wr_valid  = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       wr_ready;
    logic [6:0] cfg;
    logic       settling;
    logic       soft_res;

    int errors = 0;
    int checks = 0;

    clkset_sequencer #(
        .SETTLE_CYCLES(8),
        .RESET_CYCLES (4)
    ) dut (
        .clock_160(clock_160),
        .res      (res),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .cfg      (cfg),
        .settling (settling),
        .soft_res (soft_res)
    );

    always #5 clock_160 = ~clock_160;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic status(input string tag, input logic [6:0] e_cfg, input logic e_rdy,
                          input logic e_set, input logic e_sr);
        check({tag, ".cfg"},      {1'b0, cfg},      {1'b0, e_cfg});
        check({tag, ".wr_ready"}, {7'b0, wr_ready}, {7'b0, e_rdy});
        check({tag, ".settling"}, {7'b0, settling}, {7'b0, e_set});
        check({tag, ".soft_res"}, {7'b0, soft_res}, {7'b0, e_sr});
    endtask

    // Called at a negedge with wr_ready already high; returns at the negedge after acceptance.
    task automatic write(input logic [7:0] d);
        check("write.ready_before", {7'b0, wr_ready}, 8'h01);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clock_160);
        wr_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock_160);
        status("in_reset", 7'h00, 1'b0, 1'b0, 1'b0);
        res = 1'b0;
        @(negedge clock_160);
        status("after_reset", 7'h00, 1'b1, 1'b0, 1'b0);

        write(8'h01);
        status("wr01", 7'h01, 1'b1, 1'b0, 1'b0);
        write(8'h00);
        status("wr00", 7'h00, 1'b1, 1'b0, 1'b0);

        // Both enables rising from 0: one settle period, staged source stays RCFAST.
        write(8'h6F);
        for (int i = 0; i < 8; i++) begin
            status($sformatf("settle6F[%0d]", i), 7'h68, 1'b0, 1'b1, 1'b0);
            @(negedge clock_160);
        end
        status("settle6F.done", 7'h6F, 1'b1, 1'b0, 1'b0);

        write(8'h20);
        status("disable_pll", 7'h20, 1'b1, 1'b0, 1'b0);
        write(8'h25);
        status("same_enables", 7'h25, 1'b1, 1'b0, 1'b0);

        // PLL alone rising with a write held pending across the settle.
        write(8'h6F);
        wr_valid = 1'b1;
        wr_data  = 8'h01;
        for (int i = 0; i < 8; i++) begin
            status($sformatf("held[%0d]", i), {4'b1101, 3'b101}, 1'b0, 1'b1, 1'b0);
            @(negedge clock_160);
        end
        status("held.done", 7'h6F, 1'b1, 1'b0, 1'b0);
        @(negedge clock_160);
        wr_valid = 1'b0;
        status("held.accepted", 7'h01, 1'b1, 1'b0, 1'b0);

        write(8'h80);
        for (int i = 0; i < 4; i++) begin
            status($sformatf("softres[%0d]", i), 7'h00, 1'b0, 1'b0, 1'b1);
            @(negedge clock_160);
        end
        status("softres.done", 7'h00, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a settle clears everything without waiting for a clock.
        write(8'h6F);
        repeat (3) @(negedge clock_160);
        status("pre_abort", 7'h68, 1'b0, 1'b1, 1'b0);
        res = 1'b1;
        #1;
        status("abort", 7'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clock_160);
        res = 1'b0;
        @(negedge clock_160);
        status("abort.release", 7'h00, 1'b1, 1'b0, 1'b0);
        write(8'h01);
        status("abort.wr01", 7'h01, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
